i2c_slave_regs: RTL
===================

# i2c_slave_regs

I2C target (slave) with a small internal register bank. It sits on the `sda`/`scl` lines directly downstream of the APB-controlled I2C master and is the bus partner the master writes to and reads from. SCL and SDA are oversampled in the `i2c_clk` domain, and the block acknowledges its 7-bit address. Writes set a register pointer and store data; reads return data with pointer auto-increment.

## Interface
Parameters:
- `SLAVE_ADDR`, 7'h3C: 7-bit address the block answers to.
- `DEPTH`, 16: number of 8-bit registers. Must be a power of 2.
- `PTR_W`, 4: log2(`DEPTH`).

Ports:
- `i2c_clk`, in, 1: single clock. Must run at 16× or more the SCL frequency.
- `i2c_rst`, in, 1: reset, asynchronous, active-high.
- `scl_i`, in, 1: SCL pin value, resolved wire, asynchronous.
- `sda_i`, in, 1: SDA pin value, resolved wire, asynchronous.
- `sda_oe`, out, 1: 1 pulls SDA low (open-drain). 0 releases it.
- `busy`, out, 1: high from a detected START to a detected STOP.
- `start_det`, out, 1: one-cycle pulse on each START or repeated START.
- `stop_det`, out, 1: one-cycle pulse on STOP.
- `dbg_addr`, in, `PTR_W`: register-bank observation address.
- `dbg_data`, out, 8: `mem[dbg_addr]`, combinational.

## Operation
- **Synchronisation.** `scl_i` and `sda_i` pass through 2-flop synchronisers that reset to 1 (idle bus). Edges are detected from the synchronised value and its previous value.
- **START / STOP.** START = SDA fall while SCL high. STOP = SDA rise while SCL high.
  - START in any state: go to ADDR, clear the bit counter, release SDA.
  - STOP in any state: go to IDLE, release SDA.
- **Bit sampling.** Bits are sampled on SCL rising edges, MSB first. The bit counter runs 0..7, and the 9th SCL clock is the ACK slot.
- **States:**
  - IDLE: wait for START.
  - ADDR: shift 8 bits (addr[6:0], R/W). Then:
    - Address match: go to ACK_ADDR.
    - Mismatch, including general call 0x00: go to IDLE (NACK by not driving).
  - ACK_ADDR: on the SCL falling edge after bit 8, assert `sda_oe`. On the next SCL falling edge, release it. Then:
    - W: go to RX_PTR.
    - R: load `tx_shift = mem[ptr]`, increment `ptr`, go to TX_DATA.
  - RX_PTR: 8 bits, then `ptr <= byte[PTR_W-1:0]` (upper bits ignored). Go to ACK_PTR, which behaves like ACK_ADDR and then goes to RX_DATA.
  - RX_DATA: after 8 bits, write `mem[ptr] <= byte` and increment `ptr`, both in the cycle the 8th bit is sampled. Go to ACK_DATA, which behaves like ACK_ADDR and then returns to RX_DATA.
  - TX_DATA: on each SCL falling edge, `sda_oe = ~tx_shift[7]` and shift left. After 8 bits, release SDA on the 8th SCL falling edge and go to WAIT_MACK.
  - WAIT_MACK: sample SDA on the SCL rising edge.
    - 0 (ACK): load the next byte `mem[ptr]`, increment `ptr`, return to TX_DATA.
    - 1 (NACK): go to IDLE, SDA released.
- **Pointer.** `ptr` wraps from `DEPTH-1` to 0. It keeps its value across STOP and repeated START, so a write-pointer followed by repeated START and read is supported.
- **Reset.** On reset:
  - `sda_oe`=0, `busy`=0, `start_det`=0, `stop_det`=0.
  - `ptr`=0, all `mem`=0, state=IDLE.
  - Synchronisers reset to 1.
  - Reset mid-transfer releases SDA asynchronously.

## Timing
- Pin-to-event latency: 3 `i2c_clk` cycles (2 sync + 1 edge register).
- `sda_oe` changes in the cycle after the detected SCL falling edge. That is 3–4 `i2c_clk` after the pin edge, well inside SCL low time at 16× oversampling.
- `start_det` and `stop_det` pulse in the same cycle the state changes.
- `busy` rises on the `start_det` cycle and falls on the `stop_det` cycle.
- `mem` write is visible on `dbg_data` the cycle after the 8th data bit is sampled.
- START and SCL edge in the same cycle: START/STOP wins. This cannot arise on a legal bus and is resolved for determinism.

## Structure
- Package `i2c_slave_pkg` holds:
  - the state enum `i2c_slv_state_t` (IDLE, ADDR, ACK_ADDR, RX_PTR, ACK_PTR, RX_DATA, ACK_DATA, TX_DATA, WAIT_MACK);
  - `I2C_GENERAL_CALL = 7'h00`.
- Sub-module `i2c_bus_sync`: 2-flop synchronisers plus SCL rise/fall and START/STOP detection. Outputs are one-cycle pulses.
- Top module: FSM, shift registers, `ptr`, `mem` array.

## Test plan
- **Write.** START, 0x78 (0x3C,W), 0x05, 0xA1, 0xB2, STOP. Expect:
  - ACK on all three bytes;
  - `mem[5]`=0xA1, `mem[6]`=0xB2, `ptr`=7;
  - `busy` low after STOP.
- **Combined read.** START, 0x78, 0x0F, repeated START, 0x79, master ACK, then NACK. Expect:
  - returned bytes `mem[15]` then `mem[0]` (wrap);
  - SDA released after the NACK; `start_det` pulsed twice.
- **Address mismatch.** START, 0x50, data 0x11, STOP. Expect `sda_oe` never asserted, all `mem` unchanged.
- **Early STOP.** STOP after bit 4 of a data byte. Expect state IDLE, no `mem` write, `sda_oe`=0.
- **Reset during read.** Assert `i2c_rst` while `sda_oe`=1 during TX_DATA. Expect:
  - `sda_oe`=0 with no clock edge;
  - `ptr`=0, all `mem` read 0 via `dbg_data`.
- **Pointer wrap on write.** Write pointer 0x1E, then 3 data bytes. Expect the upper pointer bits ignored, with writes landing at `mem[14]`, `mem[15]`, `mem[0]`.

Source files
------------

// File: rtl/i2c_slave_pkg.sv
// rtl/i2c_slave_pkg.sv - shared types and constants for the I2C register target
// Contents:
//   i2c_slv_state_t  : protocol state of the target FSM
//   I2C_GENERAL_CALL : 7-bit general-call address, never acknowledged
package i2c_slave_pkg;

  typedef enum logic [3:0] {
    IDLE,
    ADDR,
    ACK_ADDR,
    RX_PTR,
    ACK_PTR,
    RX_DATA,
    ACK_DATA,
    TX_DATA,
    WAIT_MACK
  } i2c_slv_state_t;

  localparam logic [6:0] I2C_GENERAL_CALL = 7'h00;

endpackage

// File: rtl/i2c_bus_sync.sv
// rtl/i2c_bus_sync.sv - SCL/SDA synchronisers with edge and START/STOP detection
// Ports:
//   i_clk, i_rst       : oversampling clock, async active-high reset
//   i_scl, i_sda       : raw bus pin values
//   o_sda              : synchronised SDA, aligned with the event pulses
//   o_scl_rise/o_scl_fall : one-cycle SCL edge pulses
//   o_start/o_stop     : one-cycle START / STOP pulses
module i2c_bus_sync (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_scl,
  input  logic i_sda,
  output logic o_sda,
  output logic o_scl_rise,
  output logic o_scl_fall,
  output logic o_start,
  output logic o_stop
);

  logic r_scl_meta, r_scl_sync, r_scl_prev;
  logic r_sda_meta, r_sda_sync, r_sda_prev;
  logic r_scl_rise, r_scl_fall, r_start, r_stop;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      // Idle bus level so reset release never looks like an edge.
      r_scl_meta <= 1'b1;
      r_scl_sync <= 1'b1;
      r_scl_prev <= 1'b1;
      r_sda_meta <= 1'b1;
      r_sda_sync <= 1'b1;
      r_sda_prev <= 1'b1;
      r_scl_rise <= 1'b0;
      r_scl_fall <= 1'b0;
      r_start    <= 1'b0;
      r_stop     <= 1'b0;
    end else begin
      r_scl_meta <= i_scl;
      r_scl_sync <= r_scl_meta;
      r_scl_prev <= r_scl_sync;
      r_sda_meta <= i_sda;
      r_sda_sync <= r_sda_meta;
      r_sda_prev <= r_sda_sync;
      r_scl_rise <= r_scl_sync & ~r_scl_prev;
      r_scl_fall <= ~r_scl_sync & r_scl_prev;
      // SCL must be high on both samples so an SDA move next to an SCL
      // edge is never mistaken for a bus condition.
      r_start    <= r_sda_prev & ~r_sda_sync & r_scl_sync & r_scl_prev;
      r_stop     <= ~r_sda_prev & r_sda_sync & r_scl_sync & r_scl_prev;
    end
  end

  // r_sda_prev holds the SDA value seen alongside the SCL edge that the
  // registered pulses report.
  assign o_sda      = r_sda_prev;
  assign o_scl_rise = r_scl_rise;
  assign o_scl_fall = r_scl_fall;
  assign o_start    = r_start;
  assign o_stop     = r_stop;

endmodule

// File: rtl/i2c_slave_regs.sv
// rtl/i2c_slave_regs.sv - I2C target with an auto-incrementing 8-bit register bank
// Ports:
//   i2c_clk, i2c_rst     : oversampling clock (>=16x SCL), async active-high reset
//   scl_i, sda_i         : bus pin values
//   sda_oe               : 1 pulls SDA low
//   busy                 : high between START and STOP
//   start_det, stop_det  : one-cycle bus condition pulses
//   dbg_addr, dbg_data   : combinational register-bank observation port
module i2c_slave_regs
  import i2c_slave_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR = 7'h3C,
  parameter int         DEPTH      = 16,
  parameter int         PTR_W      = 4
) (
  input  logic             i2c_clk,
  input  logic             i2c_rst,
  input  logic             scl_i,
  input  logic             sda_i,
  output logic             sda_oe,
  output logic             busy,
  output logic             start_det,
  output logic             stop_det,
  input  logic [PTR_W-1:0] dbg_addr,
  output logic [7:0]       dbg_data
);

  logic w_sda, w_scl_rise, w_scl_fall, w_start, w_stop;

  i2c_bus_sync u_sync (
    .i_clk      (i2c_clk),
    .i_rst      (i2c_rst),
    .i_scl      (scl_i),
    .i_sda      (sda_i),
    .o_sda      (w_sda),
    .o_scl_rise (w_scl_rise),
    .o_scl_fall (w_scl_fall),
    .o_start    (w_start),
    .o_stop     (w_stop)
  );

  i2c_slv_state_t   r_state, w_state_nxt;
  logic [3:0]       r_bit_cnt;
  logic [6:0]       r_shift;
  logic [7:0]       r_tx_shift;
  logic [PTR_W-1:0] r_ptr;
  logic [7:0]       r_mem [DEPTH];
  logic             r_rw;
  logic             r_ack_hold;
  logic             r_sda_oe, r_busy, r_start_det, r_stop_det;

  logic [7:0]       w_rx_byte;
  logic [7:0]       w_mem_ptr;
  logic             w_byte_done;
  logic             w_addr_hit;
  logic             w_ack_end;
  logic             w_oe_nxt;

  assign w_rx_byte   = {r_shift, w_sda};
  assign w_mem_ptr   = r_mem[r_ptr];
  assign w_byte_done = w_scl_rise && (r_bit_cnt == 4'd7);
  assign w_addr_hit  = (w_rx_byte[7:1] == SLAVE_ADDR) &&
                       (w_rx_byte[7:1] != I2C_GENERAL_CALL);
  // r_ack_hold is set by the fall that starts the ACK slot, so a fall with
  // it set is the end of the ACK clock.
  assign w_ack_end   = w_scl_fall && r_ack_hold;

  // State register
  always_ff @(posedge i2c_clk or posedge i2c_rst) begin
    if (i2c_rst) r_state <= IDLE;
    else         r_state <= w_state_nxt;
  end

  // Next-state logic; bus conditions override any protocol progress.
  always_comb begin
    w_state_nxt = r_state;
    if (w_start) begin
      w_state_nxt = ADDR;
    end else if (w_stop) begin
      w_state_nxt = IDLE;
    end else begin
      case (r_state)
        IDLE:      w_state_nxt = IDLE;
        ADDR:      if (w_byte_done) w_state_nxt = w_addr_hit ? ACK_ADDR : IDLE;
        ACK_ADDR:  if (w_ack_end) w_state_nxt = r_rw ? TX_DATA : RX_PTR;
        RX_PTR:    if (w_byte_done) w_state_nxt = ACK_PTR;
        ACK_PTR:   if (w_ack_end) w_state_nxt = RX_DATA;
        RX_DATA:   if (w_byte_done) w_state_nxt = ACK_DATA;
        ACK_DATA:  if (w_ack_end) w_state_nxt = RX_DATA;
        TX_DATA:   if (w_scl_fall && (r_bit_cnt == 4'd8)) w_state_nxt = WAIT_MACK;
        WAIT_MACK: if (w_scl_rise) w_state_nxt = w_sda ? IDLE : TX_DATA;
        default:   w_state_nxt = IDLE;
      endcase
    end
  end

  // Output logic: next SDA pull-down, registered below.
  always_comb begin
    w_oe_nxt = 1'b0;
    if (!(w_start || w_stop)) begin
      case (r_state)
        ACK_ADDR, ACK_PTR, ACK_DATA: begin
          w_oe_nxt = r_sda_oe;
          if (w_scl_fall) begin
            if (!r_ack_hold)
              w_oe_nxt = 1'b1;
            else if ((r_state == ACK_ADDR) && r_rw)
              // The fall ending the address ACK is also where the first
              // read bit must appear.
              w_oe_nxt = ~w_mem_ptr[7];
            else
              w_oe_nxt = 1'b0;
          end
        end
        TX_DATA: begin
          w_oe_nxt = r_sda_oe;
          if (w_scl_fall)
            w_oe_nxt = (r_bit_cnt == 4'd8) ? 1'b0 : ~r_tx_shift[7];
        end
        default: w_oe_nxt = 1'b0;
      endcase
    end
  end

  // Datapath: shifters, bit counter, pointer, register bank, flags.
  always_ff @(posedge i2c_clk or posedge i2c_rst) begin
    if (i2c_rst) begin
      r_bit_cnt   <= '0;
      r_shift     <= '0;
      r_tx_shift  <= '0;
      r_ptr       <= '0;
      r_rw        <= 1'b0;
      r_ack_hold  <= 1'b0;
      r_sda_oe    <= 1'b0;
      r_busy      <= 1'b0;
      r_start_det <= 1'b0;
      r_stop_det  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      r_sda_oe    <= w_oe_nxt;
      r_start_det <= w_start;
      r_stop_det  <= w_stop;
      if (w_start)     r_busy <= 1'b1;
      else if (w_stop) r_busy <= 1'b0;

      if (w_start || w_stop) begin
        r_bit_cnt  <= '0;
        r_ack_hold <= 1'b0;
      end else begin
        case (r_state)
          ADDR, RX_PTR, RX_DATA: begin
            if (w_scl_rise) begin
              r_shift <= w_rx_byte[6:0];
              if (r_bit_cnt == 4'd7) begin
                r_bit_cnt  <= '0;
                r_ack_hold <= 1'b0;
                if (r_state == ADDR) r_rw <= w_sda;
                if (r_state == RX_PTR) r_ptr <= w_rx_byte[PTR_W-1:0];
                if (r_state == RX_DATA) begin
                  r_mem[r_ptr] <= w_rx_byte;
                  r_ptr        <= r_ptr + 1'b1;
                end
              end else begin
                r_bit_cnt <= r_bit_cnt + 4'd1;
              end
            end
          end
          ACK_ADDR, ACK_PTR, ACK_DATA: begin
            if (w_scl_fall) begin
              r_ack_hold <= ~r_ack_hold;
              if (r_ack_hold && (r_state == ACK_ADDR) && r_rw) begin
                // Bit 7 goes out on this same fall, so store it pre-shifted.
                r_tx_shift <= {w_mem_ptr[6:0], 1'b0};
                r_ptr      <= r_ptr + 1'b1;
              end
            end
          end
          TX_DATA: begin
            if (w_scl_rise) begin
              r_bit_cnt <= r_bit_cnt + 4'd1;
            end else if (w_scl_fall) begin
              if (r_bit_cnt == 4'd8) r_bit_cnt <= '0;
              else                   r_tx_shift <= {r_tx_shift[6:0], 1'b0};
            end
          end
          WAIT_MACK: begin
            if (w_scl_rise && !w_sda) begin
              r_tx_shift <= w_mem_ptr;
              r_ptr      <= r_ptr + 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign sda_oe    = r_sda_oe;
  assign busy      = r_busy;
  assign start_det = r_start_det;
  assign stop_det  = r_stop_det;
  assign dbg_data  = r_mem[dbg_addr];

endmodule
